// File: rtl/dc_write_arbiter_hyper_if.sv
// Write-side bus of the hyperbus TX FIFO arbiter: requester handshakes on one
// side, FIFO write port and one-hot write pointer on the other.
// master: requesters plus FIFO (environment); slave: the arbiter.
interface dc_write_arbiter_hyper_if #(
   parameter int NUM_REQ      = 4,
   parameter int ID_WIDTH     = 2,
   parameter int DATA_WIDTH   = 32,
   parameter int BUFFER_DEPTH = 8
);
   logic [NUM_REQ-1:0]            req_valid_i;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
   logic [NUM_REQ-1:0]            req_last_i;
   logic [NUM_REQ-1:0]            req_ready_o;
   logic                          fifo_full_i;
   logic                          fifo_valid_o;
   logic [DATA_WIDTH-1:0]         fifo_data_o;
   logic [ID_WIDTH-1:0]           fifo_id_o;
   logic                          fifo_last_o;
   logic [BUFFER_DEPTH-1:0]       write_pointer_o;

   modport master (
      output req_valid_i, req_data_i, req_last_i, fifo_full_i,
      input  req_ready_o, fifo_valid_o, fifo_data_o, fifo_id_o, fifo_last_o,
             write_pointer_o
   );

   modport slave (
      input  req_valid_i, req_data_i, req_last_i, fifo_full_i,
      output req_ready_o, fifo_valid_o, fifo_data_o, fifo_id_o, fifo_last_o,
             write_pointer_o
   );
endinterface

// File: rtl/dc_write_arbiter_hyper.sv
// Round-robin, burst-locked write arbiter for the hyperbus dual-clock TX FIFO.
// Lives entirely in the write (uDMA) clock domain and owns the one-hot FIFO
// write pointer. Stalls on the registered early-full flag from the FIFO.
//
// Optional macro DC_WR_ARB_TIMEOUT_EN: release a grant after TIMEOUT_CYCLES
// consecutive cycles with the owner idle (valid=0) and the FIFO not full;
// timeout_o pulses for one cycle on such a release.
//
// state | meaning
// IDLE  | no grant; arbitrate among valid requesters from rr_ptr
// BURST | grant held by grant_id until last beat, MAX_BURST cap or timeout
module dc_write_arbiter_hyper #(
   parameter int NUM_REQ        = 4,
   parameter int ID_WIDTH       = 2,
   parameter int DATA_WIDTH     = 32,
   parameter int BUFFER_DEPTH   = 8,
   parameter int MAX_BURST      = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                      clk,
   input  logic                      rstn,
   dc_write_arbiter_hyper_if.slave   bus,
   output logic                      busy_o,
   output logic                      timeout_o
);
   localparam int BC_W = $clog2(MAX_BURST) + 1;

   if (NUM_REQ < 2 || NUM_REQ > 8 || ID_WIDTH < $clog2(NUM_REQ) || BUFFER_DEPTH < 4 ||
       MAX_BURST < 2 || (MAX_BURST & (MAX_BURST - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("dc_write_arbiter_hyper: illegal parameter combination");
   end

   typedef enum logic {IDLE, BURST} state_t;

   state_t                state_q, state_d;
   logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ID_WIDTH-1:0]   grant_id_q, grant_id_d;
   logic [BC_W-1:0]       burst_cnt_q, burst_cnt_d;
   logic                  any_valid;
   logic [ID_WIDTH-1:0]   winner;
   logic                  gnt_valid, gnt_last, accept, to_hit;
   logic [DATA_WIDTH-1:0] gnt_data;

   assign busy_o = (state_q != IDLE);
   assign accept = (state_q == BURST) && gnt_valid && !bus.fifo_full_i;

   // Cyclic search from rr_ptr; descending loop so the nearest valid wins.
   always_comb begin
      winner    = rr_ptr_q;
      any_valid = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         int idx;
         idx = (int'(rr_ptr_q) + i) % NUM_REQ;
         if (bus.req_valid_i[idx]) begin
            winner    = ID_WIDTH'(idx);
            any_valid = 1'b1;
         end
      end
   end

   // Mux the granted requester's beat and drive its ready while in BURST.
   always_comb begin
      gnt_valid       = 1'b0;
      gnt_last        = 1'b0;
      gnt_data        = '0;
      bus.req_ready_o = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (ID_WIDTH'(k) == grant_id_q) begin
            gnt_valid          = bus.req_valid_i[k];
            gnt_last           = bus.req_last_i[k];
            gnt_data           = bus.req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            bus.req_ready_o[k] = (state_q == BURST) && !bus.fifo_full_i;
         end
      end
   end

`ifdef DC_WR_ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_cnt_q;
   logic            idle_beat, to_pulse_q;

   assign idle_beat = (state_q == BURST) && !gnt_valid && !bus.fifo_full_i;
   assign to_hit    = idle_beat && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
   assign timeout_o = to_pulse_q;

   // Count consecutive owner-idle cycles; any break (beat, full, exit) clears.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         to_cnt_q   <= '0;
         to_pulse_q <= 1'b0;
      end else begin
         to_pulse_q <= to_hit;
         if (!idle_beat || to_hit) to_cnt_q <= '0;
         else                      to_cnt_q <= to_cnt_q + 1'b1;
      end
   end
`else
   assign to_hit    = 1'b0;
   assign timeout_o = 1'b0;
`endif

   // Next-state logic: grant in IDLE, count beats and release in BURST.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_id_d  = grant_id_q;
      burst_cnt_d = burst_cnt_q;
      case (state_q)
         IDLE: begin
            if (any_valid) begin
               grant_id_d  = winner;
               rr_ptr_d    = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
               burst_cnt_d = '0;
               state_d     = BURST;
            end
         end
         BURST: begin
            if (accept) begin
               burst_cnt_d = burst_cnt_q + 1'b1;
               if (gnt_last || burst_cnt_q == BC_W'(MAX_BURST - 1)) state_d = IDLE;
            end else if (to_hit) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Arbiter state registers.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         grant_id_q  <= '0;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_id_q  <= grant_id_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   // Output register: one strobe per accepted beat; the pointer advances the
   // cycle after each strobe so every write lands in the slot shown with it.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         bus.fifo_valid_o    <= 1'b0;
         bus.fifo_data_o     <= '0;
         bus.fifo_id_o       <= '0;
         bus.fifo_last_o     <= 1'b0;
         bus.write_pointer_o <= BUFFER_DEPTH'(1);
      end else begin
         bus.fifo_valid_o <= accept;
         if (accept) begin
            bus.fifo_data_o <= gnt_data;
            bus.fifo_id_o   <= grant_id_q;
            bus.fifo_last_o <= gnt_last;
         end
         if (bus.fifo_valid_o)
            bus.write_pointer_o <= {bus.write_pointer_o[BUFFER_DEPTH-2:0],
                                    bus.write_pointer_o[BUFFER_DEPTH-1]};
      end
   end
endmodule

// File: tb/tb_dc_write_arbiter_hyper.sv
// Bench for dc_write_arbiter_hyper: queue-driven requesters, a transaction
// level reference model checked every cycle, and literal directed checks.
module tb_dc_write_arbiter_hyper;
   localparam int N    = 4;
   localparam int IDW  = 2;
   localparam int DW   = 32;
   localparam int BD   = 8;
   localparam int MAXB = 16;
   localparam int TO   = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rstn;
   logic busy, tout;

   dc_write_arbiter_hyper_if #(.NUM_REQ(N), .ID_WIDTH(IDW), .DATA_WIDTH(DW),
                               .BUFFER_DEPTH(BD)) bus ();

   dc_write_arbiter_hyper #(.NUM_REQ(N), .ID_WIDTH(IDW), .DATA_WIDTH(DW),
                            .BUFFER_DEPTH(BD), .MAX_BURST(MAXB),
                            .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rstn(rstn), .bus(bus), .busy_o(busy), .timeout_o(tout));

   int checks = 0;
   int errors = 0;

   // requester sources: each entry is {last, data}
   logic [DW:0] srcq [N][$];
   int          gate_pct, full_pct;
   logic        full_force;
   logic [N-1:0] hold;

   // observation logs
   int              log_id[$];
   logic            log_last[$];
   logic [BD-1:0]   log_wp[$];
   logic [DW-1:0]   log_data[$];
   int              log_cyc[$];
   int              n_tout = 0;
   int              cyc = 0;
   bit              chk_en = 0;

   // reference model state: owner=-1 means nobody holds the FIFO
   int          m_owner = -1, m_nb = 0, m_rr = 0, m_slot = 0, m_to = 0, m_id = 0;
   logic        m_fv = 0, m_last = 0, m_tout = 0, m_busy = 0;
   logic [DW-1:0] m_data = '0;
   logic [N-1:0]  m_v, m_l, m_rdy;
   logic          m_full;
   bit            m_found;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive();
      logic [N*DW-1:0] d;
      logic [N-1:0]    v, l;
      d = '0; v = '0; l = '0;
      for (int k = 0; k < N; k++) begin
         if (srcq[k].size() > 0 && !hold[k] && ($urandom_range(99) < gate_pct)) begin
            v[k] = 1'b1;
            d[k*DW +: DW] = srcq[k][0][DW-1:0];
            l[k] = srcq[k][0][DW];
         end else begin
            d[k*DW +: DW] = $urandom;
            l[k] = $urandom_range(1);
         end
      end
      bus.req_valid_i = v;
      bus.req_data_i  = d;
      bus.req_last_i  = l;
      bus.fifo_full_i = full_force || ($urandom_range(99) < full_pct);
   endtask

   task automatic step();
      logic [N-1:0] acc;
      @(negedge clk);
      acc = bus.req_valid_i & bus.req_ready_o;
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++)
         if (acc[k] && srcq[k].size() > 0) void'(srcq[k].pop_front());
      drive();
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      step();
      rstn = 1'b1;
   endtask

   task automatic clear_logs();
      log_id.delete(); log_last.delete(); log_wp.delete();
      log_data.delete(); log_cyc.delete(); n_tout = 0;
   endtask

   function automatic bit all_empty();
      for (int k = 0; k < N; k++) if (srcq[k].size() != 0) return 0;
      return 1;
   endfunction

   task automatic run_until_idle(input int budget, input string name);
      for (int c = 0; c < budget; c++) begin
         step();
         if (all_empty() && busy === 1'b0 && bus.fifo_valid_o === 1'b0) return;
      end
      checks++;
      errors++;
      $display("FAIL %s: still busy after %0d cycles, required idle", name, budget);
   endtask

   task automatic wait_log(input int n, input int budget, input string name);
      for (int c = 0; c < budget; c++) begin
         if (log_id.size() >= n) return;
         step();
      end
      checks++;
      errors++;
      $display("FAIL %s: %0d strobes seen, required %0d", name, log_id.size(), n);
   endtask

   // Per-cycle compare against the model, then advance the model with the
   // inputs that the coming clock edge will sample.
   always @(negedge clk) begin
      cyc++;
      m_v    = bus.req_valid_i;
      m_l    = bus.req_last_i;
      m_full = bus.fifo_full_i;
      if (chk_en) begin
         chk("busy", busy, m_busy);
         chk("fifo_valid", bus.fifo_valid_o, m_fv);
         chk("write_pointer", bus.write_pointer_o, 64'(1) << m_slot);
         chk("timeout", tout, m_tout);
         if (m_fv) begin
            chk("fifo_data", bus.fifo_data_o, m_data);
            chk("fifo_id", bus.fifo_id_o, m_id);
            chk("fifo_last", bus.fifo_last_o, m_last);
         end
         m_rdy = (m_owner >= 0 && !m_full) ? (N'(1) << m_owner) : '0;
         chk("ready", bus.req_ready_o, m_rdy);
      end
      if (bus.fifo_valid_o === 1'b1) begin
         log_id.push_back(int'(bus.fifo_id_o));
         log_last.push_back(bus.fifo_last_o);
         log_wp.push_back(bus.write_pointer_o);
         log_data.push_back(bus.fifo_data_o);
         log_cyc.push_back(cyc);
      end
      if (tout === 1'b1) n_tout++;

      if (!rstn) begin
         m_owner = -1; m_nb = 0; m_rr = 0; m_slot = 0; m_to = 0; m_id = 0;
         m_fv = 0; m_last = 0; m_tout = 0; m_busy = 0; m_data = '0;
      end else begin
         if (m_fv) m_slot = (m_slot + 1) % BD;
         m_fv   = 0;
         m_tout = 0;
         if (m_owner < 0) begin
            m_found = 0;
            for (int i = 0; i < N; i++) begin
               if (!m_found && m_v[(m_rr + i) % N]) begin
                  m_found = 1;
                  m_owner = (m_rr + i) % N;
               end
            end
            if (m_found) begin
               m_rr = (m_owner + 1) % N;
               m_nb = 0;
               m_to = 0;
            end
         end else if (m_v[m_owner] && !m_full) begin
            m_fv   = 1;
            m_data = bus.req_data_i[m_owner*DW +: DW];
            m_id   = m_owner;
            m_last = m_l[m_owner];
            m_nb++;
            m_to = 0;
            if (m_last || m_nb == MAXB) m_owner = -1;
         end else begin
`ifdef DC_WR_ARB_TIMEOUT_EN
            if (!m_v[m_owner] && !m_full) begin
               m_to++;
               if (m_to == TO) begin
                  m_owner = -1;
                  m_tout  = 1;
                  m_to    = 0;
               end
            end else m_to = 0;
`endif
         end
         m_busy = (m_owner >= 0);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_id[5] = '{0, 1, 2, 3, 0};
      logic [BD-1:0] exp_wp[5] = '{8'd1, 8'd2, 8'd4, 8'd8, 8'd16};
      int n_id2, n_last16, base;

      rstn = 1'b0; gate_pct = 100; full_pct = 0; full_force = 0; hold = '0;
      drive();
      step(); step();
      chk_en = 1;
      chk("rst_busy", busy, 0);
      chk("rst_fifo_valid", bus.fifo_valid_o, 0);
      chk("rst_write_pointer", bus.write_pointer_o, 1);
      chk("rst_ready", bus.req_ready_o, 0);
      rstn = 1'b1;

      // round robin with single-beat bursts
      clear_logs();
      srcq[0].push_back({1'b1, 32'h1000_0000});
      srcq[0].push_back({1'b1, 32'h1000_0004});
      srcq[1].push_back({1'b1, 32'h1100_0000});
      srcq[2].push_back({1'b1, 32'h1200_0000});
      srcq[3].push_back({1'b1, 32'h1300_0000});
      drive();
      run_until_idle(100, "rr_drain");
      chk("rr_count", log_id.size(), 5);
      for (int i = 0; i < 5 && i < log_id.size(); i++) begin
         chk("rr_id", log_id[i], exp_id[i]);
         chk("rr_wp", log_wp[i], exp_wp[i]);
         if (i > 0) chk("rr_gap", log_cyc[i] - log_cyc[i-1], 2);
      end

      // 20-beat burst: cap release after 16, re-grant for 4
      clear_logs();
      for (int i = 0; i < 20; i++) srcq[2].push_back({(i == 19), 32'h2000_0000 + i});
      drive();
      run_until_idle(200, "cap_drain");
      chk("cap_count", log_id.size(), 20);
      n_id2 = 0; n_last16 = 0;
      foreach (log_id[i]) if (log_id[i] == 2) n_id2++;
      for (int i = 0; i < 16 && i < log_last.size(); i++) if (log_last[i]) n_last16++;
      chk("cap_all_id2", n_id2, 20);
      chk("cap_no_last_first16", n_last16, 0);
      if (log_id.size() == 20) begin
         chk("cap_last_beat20", log_last[19], 1);
         chk("cap_release_gap", log_cyc[16] - log_cyc[15], 2);
         chk("cap_inburst_gap", log_cyc[15] - log_cyc[14], 1);
      end

      // full stall of 5 cycles mid-burst
      clear_logs();
      for (int i = 0; i < 8; i++) srcq[1].push_back({(i == 7), 32'h3000_0000 + i});
      drive();
      repeat (4) step();
      full_force = 1; drive();
      repeat (5) step();
      full_force = 0; drive();
      run_until_idle(100, "stall_drain");
      chk("stall_count", log_data.size(), 8);
      for (int i = 0; i < 8 && i < log_data.size(); i++)
         chk("stall_data", log_data[i], 32'h3000_0000 + i);
      if (log_cyc.size() == 8) chk("stall_span", log_cyc[7] - log_cyc[0], 12);

      // pointer wrap over 9 singles
      do_reset();
      clear_logs();
      for (int i = 0; i < 9; i++) srcq[3].push_back({1'b1, 32'h4000_0000 + i});
      drive();
      run_until_idle(100, "wrap_drain");
      chk("wrap_count", log_wp.size(), 9);
      if (log_wp.size() == 9) begin
         chk("wrap_first", log_wp[0], 1);
         chk("wrap_eighth", log_wp[7], 128);
         chk("wrap_ninth", log_wp[8], 1);
      end

      // reset mid-burst
      clear_logs();
      for (int i = 0; i < 6; i++) srcq[2].push_back({(i == 5), 32'h5000_0000 + i});
      drive();
      wait_log(2, 50, "midrst_wait");
      do_reset();
      chk("midrst_busy", busy, 0);
      chk("midrst_fifo_valid", bus.fifo_valid_o, 0);
      chk("midrst_write_pointer", bus.write_pointer_o, 1);
      for (int k = 0; k < N; k++) srcq[k].delete();
      clear_logs();
      srcq[1].push_back({1'b1, 32'h5100_0000});
      srcq[3].push_back({1'b1, 32'h5300_0000});
      drive();
      run_until_idle(100, "midrst_drain");
      chk("midrst_count", log_id.size(), 2);
      if (log_id.size() >= 1) chk("midrst_rr_first", log_id[0], 1);

      // owner drops valid while another requester waits
      clear_logs();
      for (int i = 0; i < 4; i++) srcq[0].push_back({(i == 3), 32'h6000_0000 + i});
      srcq[1].push_back({1'b1, 32'h6100_0000});
      drive();
      wait_log(1, 20, "to_wait");
      hold[0] = 1'b1; drive();
      repeat (80) step();
`ifdef DC_WR_ARB_TIMEOUT_EN
      chk("to_pulses", n_tout, 1);
      chk("to_count", log_id.size(), 3);
      if (log_id.size() >= 3) chk("to_next_grant", log_id[2], 1);
`else
      chk("lock_pulses", n_tout, 0);
      chk("lock_busy", busy, 1);
      chk("lock_count", log_id.size(), 2);
`endif
      hold = '0; drive();
      run_until_idle(100, "to_drain");
      chk("to_total", log_id.size(), 5);
`ifndef DC_WR_ARB_TIMEOUT_EN
      if (log_id.size() == 5) chk("lock_last_id", log_id[4], 1);
`endif

      // randomized traffic with random stalls and occasional resets
      do_reset();
      gate_pct = 70; full_pct = 20;
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < N; k++) begin
            if (srcq[k].size() == 0 && $urandom_range(9) == 0) begin
               base = $urandom_range(1, 40);
               for (int b = 0; b < base; b++) srcq[k].push_back({(b == base - 1), 32'($urandom)});
            end
         end
         if ($urandom_range(999) == 0) rstn = 1'b0;
         step();
         rstn = 1'b1;
      end
      gate_pct = 100; full_pct = 0; drive();
      run_until_idle(2000, "random_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dc_write_arbiter_hyper.md
Name: dc_write_arbiter_hyper

Overview:
- Round-robin, burst-locked arbiter that shares the write side of the hyperbus dual-clock TX FIFO between NUM_REQ uDMA requesters.
- Sequences beats into the FIFO and owns the one-hot write pointer.
- Consumes the registered full flag produced by the FIFO's write-side full detector, and stalls on it.
- Sits entirely in the write (uDMA) clock domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_WIDTH, 2, width of the source ID; must be at least clog2(NUM_REQ).
- DATA_WIDTH, 32, beat width.
- BUFFER_DEPTH, 8, FIFO slots; width of the one-hot write pointer (≥4).
- MAX_BURST, 16, beats per grant before forced release (power of two, ≥2).
- TIMEOUT_CYCLES, 64, idle-valid cycles before release (optional feature only).

Ports:
- clk  in  1  write-domain clock
- rstn  in  1  synchronous active-low reset
- req_valid_i  in  NUM_REQ  per-requester beat valid
- req_data_i  in  NUM_REQ*DATA_WIDTH  packed beats; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
- req_last_i  in  NUM_REQ  last beat of requester burst
- req_ready_o  out  NUM_REQ  beat accepted when valid&ready
- fifo_full_i  in  1  full flag from the FIFO's write-side full detector
- fifo_valid_o  out  1  write strobe into FIFO slot write_pointer_o
- fifo_data_o  out  DATA_WIDTH  beat written
- fifo_id_o  out  ID_WIDTH  source requester index
- fifo_last_o  out  1  beat carries req_last_i
- write_pointer_o  out  BUFFER_DEPTH  one-hot write pointer
- busy_o  out  1  state != IDLE
- timeout_o  out  1  one-cycle pulse on timeout release (optional feature)

Behaviour:
- Interface: one clock `clk`; reset `rstn` is synchronous and active-low. All flops are reset only on a clk edge with rstn=0.
- Reset values:
  - state=IDLE; rr_ptr=0; grant_id=0; burst_cnt=0.
  - write_pointer_o=1 (bit0 set).
  - fifo_valid_o=0, fifo_data_o=0, fifo_id_o=0, fifo_last_o=0.
  - busy_o=0; timeout_o=0.
- FSM:
  - IDLE: if any req_valid_i, select the first requester with valid set, searching cyclically from rr_ptr. Register it into grant_id, set rr_ptr=(winner+1) mod NUM_REQ, clear burst_cnt, go to BURST. One cycle of arbitration latency.
  - BURST: req_ready_o[grant_id] = ~fifo_full_i. All other ready bits are 0. Ready is 0 for every requester in IDLE.
  - On accept (valid & ready):
    - next cycle fifo_valid_o=1, fifo_data_o=beat, fifo_id_o=grant_id, fifo_last_o=req_last_i;
    - burst_cnt increments.
  - Exit BURST to IDLE after the accepted beat with req_last_i=1, or after the accepted beat that makes burst_cnt==MAX_BURST (forced release; fifo_last_o stays 0).
- Inter-burst gap: the back-to-back burst gap is one idle cycle (IDLE).
- Output stage:
  - fifo_valid_o is a registered one-cycle strobe per beat.
  - write_pointer_o rotates left by one (MSB wraps to bit0) in the cycle after each fifo_valid_o. Each write therefore lands in the slot shown during the strobe.
  - The detector's two-slot early-full margin covers the one-cycle output-register lag, so no overflow can occur.
- Stall: with fifo_full_i=1 in BURST, ready=0 and burst_cnt holds; the grant is kept. If full clears, transfer resumes the next cycle.
- Burst lock: without the optional feature, the grant is held even if the granted requester drops valid. Other requesters wait indefinitely.
- Simultaneous events:
  - full rising in the same cycle as a valid beat: the beat is not accepted.
  - last beat and cap beat coincide: fifo_last_o=1, single exit.
- Reset mid-burst: the in-flight output beat is dropped (fifo_valid_o=0 next cycle) and the pointer returns to bit0. The FIFO is reset by the same reset.
- Widths: burst_cnt is clog2(MAX_BURST)+1 bits and rr_ptr is ID_WIDTH bits, with no overflow (burst_cnt is cleared on grant).

Optional Feature:
- Macro: DC_WR_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in BURST while the granted req_valid_i=0 and fifo_full_i=0.
  - At TIMEOUT_CYCLES consecutive such cycles, the block releases to IDLE and pulses timeout_o for one cycle.
  - The counter clears on any accepted beat.
- Undefined: no counter; timeout_o tied 0; the grant is held until last or cap.

Test Plan:
- Reset, then all valid=1 with last on the first beat each -> grants in order 0,1,2,3,0; fifo_id_o sequence 0,1,2,3,0; one idle cycle between beats; write_pointer_o steps 1,2,4,8,16.
- Requester 2 sends 20 beats, no last, MAX_BURST=16 -> 16 strobes with id=2, fifo_last_o=0, release; re-grant to 2 (only requester) for 4 beats, last=1 on the 4th.
- fifo_full_i forced 1 for 5 cycles mid-burst -> req_ready_o=0, no fifo_valid_o, burst_cnt frozen; resumes the cycle after full clears, no beat lost or duplicated.
- 9 single beats -> write_pointer_o wraps 128→1 after the 8th strobe.
- rstn low for 1 cycle during beat 3 of a burst -> next cycle busy_o=0, fifo_valid_o=0, write_pointer_o=1, rr_ptr=0.
- DC_WR_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=64: granted requester drops valid -> timeout_o pulses on cycle 64, then the next pending requester is granted. Without the macro -> no release and timeout_o=0.
